// File: rtl/enc_pkg.sv
// Shared constants and state type for the 8-to-3 encoder front end.
package enc_pkg;

   localparam int ENC_N = 8;
   localparam int ENC_W = 3;

   typedef enum logic [0:0] {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } state_e;

endpackage

// File: rtl/onehot_req_latch_if.sv
// Request/grant bundle between the request sources, the latch and the encoder side.
interface onehot_req_latch_if #(
   parameter int N = 8
);
   logic [N-1:0] req_in;
   logic         ready;
   logic         valid;
   logic [N-1:0] onehot_out;
   logic [N-1:0] pending;
   logic         drop;
   logic [7:0]   drop_cnt;

   modport master (
      output req_in, ready,
      input  valid, onehot_out, pending, drop, drop_cnt
   );

   modport slave (
      input  req_in, ready,
      output valid, onehot_out, pending, drop, drop_cnt
   );
endinterface

// File: rtl/onehot_req_latch_rr_arb8.sv
// Combinational round-robin picker: first candidate after ptr, wrapping 7 -> 0.
module rr_arb8
   import enc_pkg::*;
(
   input  logic [ENC_N-1:0] cand,
   input  logic [ENC_W-1:0] ptr,
   output logic [ENC_N-1:0] grant_onehot,
   output logic [ENC_W-1:0] grant_idx,
   output logic             any
);

   logic [ENC_W-1:0] idx_s;

   // Scan ptr+1 .. ptr+8; the 3-bit add wraps naturally.
   always_comb begin
      grant_onehot = {ENC_N{1'b0}};
      grant_idx    = {ENC_W{1'b0}};
      any          = 1'b0;
      idx_s        = {ENC_W{1'b0}};
      for (int k = 1; k <= ENC_N; k++) begin
         idx_s = ptr + ENC_W'(k);
         if (!any && cand[idx_s]) begin
            any                 = 1'b1;
            grant_idx           = idx_s;
            grant_onehot[idx_s] = 1'b1;
         end else begin
            any = any;
         end
      end
   end

endmodule

// File: rtl/onehot_req_latch.sv
// Rising-edge request capture with pending hold, presented one grant at a time
// as a one-hot vector with valid/ready in front of the 8-to-3 encoder.
module onehot_req_latch
   import enc_pkg::*;
#(
   parameter int N           = ENC_N,
   parameter int SYNC_STAGES = 2
) (
   input logic               clk,
   input logic               rst_n,
   onehot_req_latch_if.slave bus
);

   logic [SYNC_STAGES-1:0][N-1:0] sync_q, sync_d;
   logic [N-1:0]                  prev_q, prev_d;
   logic [N-1:0]                  pending_q, pending_d;
   logic [N-1:0]                  onehot_q, onehot_d;
   logic [ENC_W-1:0]              out_idx_q, out_idx_d;
   logic [ENC_W-1:0]              ptr_q, ptr_d;
   state_e                        state_q, state_d;
   logic                          drop_q, drop_d;
   logic [7:0]                    drop_cnt_q, drop_cnt_d;

   logic [N-1:0]     edge_s, acc_vec_s, drop_vec_s, cand_s, grant_s;
   logic [ENC_W-1:0] grant_idx_s, arb_ptr_s;
   logic             accept_s, load_s, any_s;

   rr_arb8 u_arb (
      .cand         (cand_s),
      .ptr          (arb_ptr_s),
      .grant_onehot (grant_s),
      .grant_idx    (grant_idx_s),
      .any          (any_s)
   );

   // Edge capture, pending update, drop detection and arbiter inputs.
   always_comb begin
      sync_d     = {sync_q[SYNC_STAGES-2:0], bus.req_in};
      prev_d     = sync_q[SYNC_STAGES-1];
      edge_s     = sync_q[SYNC_STAGES-1] & ~prev_q;
      accept_s   = (state_q == FULL) && bus.ready;
      acc_vec_s  = accept_s ? onehot_q : {N{1'b0}};
      // Set wins over the acceptance clear, so an edge on the accepted bit is not a drop.
      drop_vec_s = edge_s & pending_q & ~acc_vec_s;
      pending_d  = (pending_q & ~acc_vec_s) | edge_s;
      load_s     = (state_q == EMPTY) || accept_s;
      cand_s     = load_s ? (pending_q & ~onehot_q) : {N{1'b0}};
      arb_ptr_s  = accept_s ? out_idx_q : ptr_q;
      ptr_d      = arb_ptr_s;
      drop_d     = |drop_vec_s;
      if (drop_d && (drop_cnt_q != 8'd255)) begin
         drop_cnt_d = drop_cnt_q + 8'd1;
      end else begin
         drop_cnt_d = drop_cnt_q;
      end
   end

   // Next-state logic of the output register.
   always_comb begin
      state_d = state_q;
      case (state_q)
         EMPTY:   state_d = any_s ? FULL : EMPTY;
         FULL:    state_d = (accept_s && !any_s) ? EMPTY : FULL;
         default: state_d = EMPTY;
      endcase
   end

   // Output register contents: reload on empty or acceptance, otherwise hold.
   always_comb begin
      onehot_d  = onehot_q;
      out_idx_d = out_idx_q;
      if (load_s) begin
         onehot_d  = grant_s;
         out_idx_d = grant_idx_s;
      end else begin
         onehot_d  = onehot_q;
         out_idx_d = out_idx_q;
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= EMPTY;
      end else begin
         state_q <= state_d;
      end
   end

   // Datapath registers; ptr resets to the top index so line 0 wins first.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync_q     <= {(SYNC_STAGES*N){1'b0}};
         prev_q     <= {N{1'b0}};
         pending_q  <= {N{1'b0}};
         onehot_q   <= {N{1'b0}};
         out_idx_q  <= {ENC_W{1'b0}};
         ptr_q      <= ENC_W'(N - 1);
         drop_q     <= 1'b0;
         drop_cnt_q <= 8'd0;
      end else begin
         sync_q     <= sync_d;
         prev_q     <= prev_d;
         pending_q  <= pending_d;
         onehot_q   <= onehot_d;
         out_idx_q  <= out_idx_d;
         ptr_q      <= ptr_d;
         drop_q     <= drop_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

   assign bus.valid      = (state_q == FULL);
   assign bus.onehot_out = onehot_q;
   assign bus.pending    = pending_q;
   assign bus.drop       = drop_q;
   assign bus.drop_cnt   = drop_cnt_q;

endmodule

// File: tb/tb_onehot_req_latch.sv
// Scoreboard bench for onehot_req_latch: directed stimulus pushes expected grants,
// a negedge monitor pops and compares them on every accepted transfer.
module tb_onehot_req_latch;
   import enc_pkg::*;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   onehot_req_latch_if #(.N(8)) bus ();

   onehot_req_latch #(.N(8), .SYNC_STAGES(2)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int         checks = 0;
   int         errors = 0;
   int         drop_pulses = 0;
   logic [7:0] exp_q[$];
   logic       hold_act = 1'b0;
   logic [7:0] hold_val = 8'd0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [2:0] enc8(input logic [7:0] oh);
      logic [2:0] r;
      r = 3'd0;
      for (int i = 0; i < 8; i++) begin
         if (oh[i]) r = 3'(i);
      end
      return r;
   endfunction

   // Monitor: grant scoreboard, hold stability under backpressure, one-hot shape, drop pulses.
   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         if (bus.drop === 1'b1) drop_pulses++;
         if (hold_act) check("hold_stable", bus.onehot_out, hold_val);
         if (bus.valid === 1'b1) begin
            check("onehot_shape", $countones(bus.onehot_out), 1);
         end else begin
            check("idle_zero", bus.onehot_out, 8'h00);
         end
         if (bus.valid === 1'b1 && bus.ready === 1'b1) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_grant actual=%0h required=none", bus.onehot_out);
            end else begin
               check("grant", bus.onehot_out, exp_q.pop_front());
            end
         end
         hold_act = (bus.valid === 1'b1) && (bus.ready === 1'b0);
         hold_val = bus.onehot_out;
      end else begin
         hold_act = 1'b0;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_valid(input int budget);
      for (int i = 0; i < budget && bus.valid !== 1'b1; i++) tick();
      check("wait_valid", bus.valid, 1'b1);
   endtask

   task automatic drain(input int budget);
      int n;
      n = 0;
      while ((exp_q.size() != 0 || bus.valid === 1'b1) && n < budget) begin
         tick();
         n++;
      end
      check("drain_queue", exp_q.size(), 0);
      check("drain_valid", bus.valid, 1'b0);
   endtask

   task automatic pulse(input logic [7:0] v);
      bus.req_in = v;
      tick();
      bus.req_in = 8'h00;
      tick();
   endtask

   initial begin
      int base;
      rst_n      = 1'b0;
      bus.req_in = 8'hFF;
      bus.ready  = 1'b1;

      // Reset with all lines high: outputs cleared, then one grant per line in order.
      tick();
      tick();
      check("rst_valid", bus.valid, 1'b0);
      check("rst_onehot", bus.onehot_out, 8'h00);
      check("rst_pending", bus.pending, 8'h00);
      check("rst_drop", bus.drop, 1'b0);
      check("rst_drop_cnt", bus.drop_cnt, 8'd0);
      for (int i = 0; i < 8; i++) exp_q.push_back(8'h01 << i);
      rst_n = 1'b1;
      drain(40);
      check("rst_pending_after", bus.pending, 8'h00);
      bus.req_in = 8'h00;
      repeat (4) tick();

      // Single request: latency of SYNC_STAGES+1 edges, encoder sees index 4.
      bus.req_in = 8'h10;
      exp_q.push_back(8'h10);
      tick();
      check("lat_e0", bus.valid, 1'b0);
      tick();
      check("lat_e1", bus.valid, 1'b0);
      tick();
      check("lat_e2", bus.valid, 1'b0);
      check("lat_e2_pending", bus.pending, 8'h10);
      tick();
      check("lat_e3", bus.valid, 1'b1);
      check("single_onehot", bus.onehot_out, 8'h10);
      check("single_enc", enc8(bus.onehot_out), 3'b100);
      tick();
      check("single_done", bus.valid, 1'b0);
      check("single_pending", bus.pending, 8'h00);
      bus.req_in = 8'h00;
      repeat (4) tick();

      // Backpressure: bit 3 held while ready low, then bit 4 back to back.
      bus.ready  = 1'b0;
      bus.req_in = 8'h18;
      exp_q.push_back(8'h08);
      exp_q.push_back(8'h10);
      wait_valid(10);
      for (int i = 0; i < 5; i++) begin
         check("bp_hold", bus.onehot_out, 8'h08);
         tick();
      end
      bus.ready = 1'b1;
      tick();
      check("bp_second_valid", bus.valid, 1'b1);
      check("bp_second", bus.onehot_out, 8'h10);
      tick();
      check("bp_empty", bus.valid, 1'b0);
      bus.req_in = 8'h00;
      repeat (4) tick();

      // Round robin: grant bit 2 to set ptr=2, then pending 0x05 wraps to bit 0 first.
      bus.req_in = 8'h04;
      exp_q.push_back(8'h04);
      drain(20);
      bus.req_in = 8'h00;
      repeat (4) tick();
      bus.ready  = 1'b0;
      bus.req_in = 8'h05;
      exp_q.push_back(8'h01);
      exp_q.push_back(8'h04);
      wait_valid(10);
      check("rr_first", bus.onehot_out, 8'h01);
      check("rr_pending", bus.pending, 8'h05);
      bus.ready = 1'b1;
      tick();
      check("rr_second", bus.onehot_out, 8'h04);
      drain(20);
      bus.req_in = 8'h00;
      repeat (4) tick();

      // Drop: second bit-5 event while bit 5 is offered.
      bus.ready = 1'b0;
      base = drop_pulses;
      pulse(8'h20);
      exp_q.push_back(8'h20);
      wait_valid(10);
      check("drop_offer", bus.onehot_out, 8'h20);
      pulse(8'h20);
      repeat (5) tick();
      check("drop_cnt_1", bus.drop_cnt, 8'd1);
      check("drop_pulses_1", drop_pulses - base, 1);
      check("drop_still_offered", bus.onehot_out, 8'h20);
      bus.ready = 1'b1;
      drain(20);
      check("drop_pending", bus.pending, 8'h00);

      // Set-wins: edge on bit 6 lands in the cycle bit 6 is accepted.
      bus.ready = 1'b0;
      base = drop_pulses;
      pulse(8'h40);
      exp_q.push_back(8'h40);
      exp_q.push_back(8'h40);
      wait_valid(10);
      repeat (3) tick();
      bus.req_in = 8'h40;
      tick();
      tick();
      bus.ready = 1'b1;
      tick();
      check("sw_pending", bus.pending, 8'h40);
      check("sw_gap", bus.valid, 1'b0);
      check("sw_drop_cnt", bus.drop_cnt, 8'd1);
      bus.req_in = 8'h00;
      drain(20);
      check("sw_no_drop", drop_pulses - base, 0);
      check("sw_pending_clear", bus.pending, 8'h00);

      // Saturation: 300 drops on bit 7 while it is offered.
      bus.ready = 1'b0;
      pulse(8'h80);
      exp_q.push_back(8'h80);
      wait_valid(10);
      base = drop_pulses;
      repeat (100) pulse(8'h80);
      repeat (4) tick();
      check("sat_mid", bus.drop_cnt, 8'd101);
      repeat (200) pulse(8'h80);
      repeat (4) tick();
      check("sat_cnt", bus.drop_cnt, 8'd255);
      check("sat_pulses", drop_pulses - base, 300);
      bus.ready = 1'b1;
      drain(20);
      check("sat_end_pending", bus.pending, 8'h00);

      check("final_queue", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/onehot_req_latch.md
# onehot_req_latch

- Upstream request stage for the 8-to-3 encoder `enc`.
- Captures rising edges on eight independent request lines, holds them as pending events, and presents them one at a time as a one-hot vector with a valid/ready handshake.
- Its `onehot_out` drives the encoder's 8-bit input directly, so the encoder only ever sees zero or exactly one set bit.

## Interface
- `N`, 8: number of request lines; the encoder width is fixed at 8.
- `SYNC_STAGES`, 2: flip-flop stages in each input synchronizer (minimum 2).
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: reset, synchronous and active-low.
- `req_in` input N: asynchronous level request lines; a 0→1 transition is one event.
- `ready` input 1: downstream accepts `onehot_out` when `valid && ready`.
- `valid` output 1: `onehot_out` holds a request.
- `onehot_out` output N: exactly one bit set when `valid`=1, all zero otherwise.
- `pending` output N: current pending-event register.
- `drop` output 1: one-cycle pulse; an event arrived on a line that was already pending.
- `drop_cnt` output 8: saturating count of dropped events.

## Operation
- **Input capture:**
  - Each `req_in[i]` passes through a `SYNC_STAGES`-deep synchronizer, then a one-flop delay `prev[i]`.
  - `edge[i] = sync_last[i] & ~prev[i]`.
- **Pending register:**
  - `edge[i]` sets `pending[i]`.
  - Acceptance of grant `i` clears `pending[i]`.
  - If both happen in the same cycle, set wins: the bit stays 1 and no drop is counted.
- **Drop:**
  - Raised when `edge[i]` fires while `pending[i]`=1 and `i` is not being accepted that cycle.
  - Multiple simultaneous drops count as one `drop` pulse and one increment.
  - `drop_cnt` saturates at 255.
- **Arbitration (round robin):**
  - Pointer `ptr` holds the last accepted index.
  - Search order is `ptr+1, ptr+2, …` with wrap from N-1 to 0.
  - Candidates are `pending & ~onehot_out` when the output register is being accepted or is empty.
- **Output register, two states:**
  - **EMPTY:** `valid`=0, `onehot_out`=0. If any candidate exists, load the selected one-hot and set `valid` next cycle; go to FULL.
  - **FULL:** `valid`=1. While `ready`=0, `onehot_out` holds stable. On `valid && ready`:
    - clear that pending bit and set `ptr` to its index;
    - if another candidate exists, load it at the same edge and stay FULL (back-to-back, one grant per cycle);
    - otherwise go to EMPTY.
- **Offered bits:** a bit currently on `onehot_out` is never re-offered until accepted. A new edge on it while offered counts as a drop (set-wins applies only in the acceptance cycle).

## Timing
- **Reset** (`rst_n`=0 at a rising edge), next-cycle values:
  - synchronizers and `prev` = 0;
  - `pending`=0, `valid`=0, `onehot_out`=0, `drop`=0, `drop_cnt`=0;
  - `ptr`=N-1, so index 0 has first priority.
- **Reset mid-transfer:** reset discards the offered and pending requests with no acceptance.
- **Line high through reset:** a line held high across reset produces one event after release, because the synchronizer starts at 0.
- **Latency:** `req_in[i]` sampled high at edge 0 gives `valid`=1 after edge `SYNC_STAGES+1`, i.e. edge 3 for the default.
- **Handshake:**
  - `valid` never drops without acceptance.
  - `onehot_out` never changes while `valid && !ready`.
  - `ready` may be high while `valid`=0; this has no effect.
- **Throughput:** one accepted request per cycle when `ready` is held high and requests are pending.
- **`drop`:** registered, high exactly one cycle per drop cycle.

## Structure
- **Shared package `enc_pkg`:**
  - `ENC_N = 8`;
  - `ENC_W = 3` (the encoder output width);
  - the state enum `{EMPTY, FULL}`.
- **Sub-module `rr_arb8`:** combinational round-robin picker.
  - Inputs: `cand[N]`, `ptr[ENC_W]`.
  - Outputs: `grant_onehot[N]`, `grant_idx[ENC_W]`, `any`.
- **Top level:** synchronizers, edge detect, pending register, state flop and counters stay in the top.

## Test plan
- **Reset:**
  - Stimulus: hold `rst_n`=0 for 2 cycles with `req_in`=8'hFF.
  - Response: all outputs 0. After release, `valid` rises at the 3rd edge with `onehot_out`=8'b00000001, then 02, 04 … 80 on consecutive cycles with `ready`=1.
- **Single request:**
  - Stimulus: `req_in`=8'b00010000, `ready`=1.
  - Response: one `valid` cycle with `onehot_out`=8'b00010000; the downstream `enc` output equals 3'b100; `pending` returns to 0.
- **Backpressure:**
  - Stimulus: requests on bits 3 and 4 (8'b00011000) simultaneously, `ready`=0 for 5 cycles, then 1.
  - Response: `onehot_out`=8'b00001000 stable for all 5 cycles, then 8'b00010000 the next cycle, then `valid`=0.
- **Round-robin fairness:**
  - Stimulus: with `ptr`=2, pending=8'b00000101.
  - Response: grant bit 0 first (wraps past bits 3..7), then bit 2.
- **Drop:**
  - Stimulus: pulse `req_in[5]` twice while bit 5 is held on the output with `ready`=0.
  - Response: one `drop` pulse, `drop_cnt`=1, a single bit-5 grant.
- **Set-wins:**
  - Stimulus: `edge[6]` in the same cycle bit 6 is accepted.
  - Response: `pending[6]` stays 1, a second bit-6 grant follows, `drop_cnt` unchanged.
- **Saturation:**
  - Stimulus: 300 drops.
  - Response: `drop_cnt`=255.
